// File: rtl/sv32_ptw.sv
`default_nettype none
// ============================================================================
// Module   : sv32_ptw
// Desc     : Sv32 two-level page-table walker, initiator on the LFM word-fetch
//            interface. Optional last-translation cache: PTW_LAST_XLATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sv32_ptw #(
   parameter int LEVELS    = 2,
   parameter int PTE_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_va,
   input  logic [1:0]  req_type,
   input  logic [1:0]  priv,
   input  logic        sstatus_sum,
   input  logic [31:0] csr_satp,
   input  logic        sfence_vma,
   output logic [31:0] LFM,
   output logic        LFM_enable,
   input  logic        LFM_resolved,
   input  logic [7:0]  b1,
   input  logic [7:0]  b2,
   input  logic [7:0]  b3,
   input  logic [7:0]  b4,
   output logic        resp_valid,
   output logic [31:0] resp_pa,
   output logic        instr_fault,
   output logic        load_fault,
   output logic        store_fault,
   output logic [31:0] faulting_va,
   output logic        stall
);

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_L1_REQ  = 3'd1;
   localparam logic [2:0] c_ST_L1_WAIT = 3'd2;
   localparam logic [2:0] c_ST_L0_REQ  = 3'd3;
   localparam logic [2:0] c_ST_L0_WAIT = 3'd4;
   localparam logic [2:0] c_ST_RESP    = 3'd5;

   localparam logic [1:0] c_T_INST  = 2'b01;
   localparam logic [1:0] c_T_LOAD  = 2'b10;
   localparam logic [1:0] c_T_STORE = 2'b11;

   localparam logic [1:0] c_PRIV_U = 2'b00;
   localparam logic [1:0] c_PRIV_S = 2'b01;
   localparam logic [1:0] c_PRIV_M = 2'b11;

   generate
      if (LEVELS != 2 || PTE_BYTES != 4) begin : g_cfg_check
         $error("sv32_ptw supports only LEVELS=2 and PTE_BYTES=4");
      end
   endgenerate

   logic [2:0]  state_q, state_d;
   logic [31:0] va_q;
   logic [1:0]  type_q;
   logic [1:0]  priv_q;
   logic        sum_q;
   logic [31:0] lfm_q, lfm_d;
   logic [31:0] pa_q, pa_d;
   logic [2:0]  flt_q, flt_d;
   logic [31:0] fva_q, fva_d;

   logic        w_accept;
   logic        w_bare;
   logic        w_hit;
   logic        w_in_idle;
   logic [31:0] w_pte;
   logic [31:0] w_cur_va;
   logic [31:0] w_chk_pte;
   logic        w_chk_super;
   logic [1:0]  w_chk_type;
   logic [1:0]  w_chk_priv;
   logic        w_chk_sum;
   logic        w_chk_invalid;
   logic        w_chk_leaf;
   logic        w_chk_perm_fault;
   logic [31:0] w_chk_pa;
   logic        w_res_load;
   logic        w_res_fault;
   logic [31:0] w_res_pa;
   logic        w_unused;

   assign w_in_idle = (state_q == c_ST_IDLE);
   assign w_accept  = w_in_idle && req_valid && (req_type != 2'b00);
   assign w_bare    = !csr_satp[31] || (priv == c_PRIV_M);
   assign w_pte     = {b4, b3, b2, b1};

   // In IDLE the checker looks at the live request (cache hit); otherwise at the walk.
   assign w_cur_va   = w_in_idle ? req_va      : va_q;
   assign w_chk_type = w_in_idle ? req_type    : type_q;
   assign w_chk_priv = w_in_idle ? priv        : priv_q;
   assign w_chk_sum  = w_in_idle ? sstatus_sum : sum_q;

`ifdef PTW_LAST_XLATE_EN
   logic        xc_vld_q;
   logic [19:0] xc_vpn_q;
   logic [31:0] xc_satp_q;
   logic [31:0] xc_pte_q;
   logic [1:0]  xc_priv_q;
   logic        xc_sum_q;
   logic        xc_super_q;
   logic [31:0] satp_q;
   logic        w_fill;

   assign w_hit = xc_vld_q && (xc_satp_q == csr_satp) && (xc_priv_q == priv) &&
                  (xc_sum_q == sstatus_sum) &&
                  (xc_super_q ? (xc_vpn_q[19:10] == req_va[31:22])
                              : (xc_vpn_q == req_va[31:12]));

   assign w_fill = ((state_q == c_ST_L1_WAIT) || (state_q == c_ST_L0_WAIT)) && LFM_resolved &&
                   !w_chk_invalid && w_chk_leaf && !w_chk_perm_fault;

   assign w_chk_pte   = w_in_idle ? xc_pte_q   : w_pte;
   assign w_chk_super = w_in_idle ? xc_super_q : (state_q == c_ST_L1_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xc_vld_q   <= 1'b0;
         xc_vpn_q   <= '0;
         xc_satp_q  <= '0;
         xc_pte_q   <= '0;
         xc_priv_q  <= '0;
         xc_sum_q   <= 1'b0;
         xc_super_q <= 1'b0;
         satp_q     <= '0;
      end else begin
         if (w_accept) begin
            satp_q <= csr_satp;
         end
         if (sfence_vma || (xc_vld_q && (csr_satp != xc_satp_q))) begin
            xc_vld_q <= 1'b0;
         end else if (w_fill) begin
            xc_vld_q   <= 1'b1;
            xc_vpn_q   <= va_q[31:12];
            xc_satp_q  <= satp_q;
            xc_pte_q   <= w_pte;
            xc_priv_q  <= priv_q;
            xc_sum_q   <= sum_q;
            xc_super_q <= w_chk_super;
         end
      end
   end

   assign w_unused = ^{w_chk_pte[31:30], w_chk_pte[9:8], w_chk_pte[5]};
`else
   assign w_hit       = 1'b0;
   assign w_chk_pte   = w_pte;
   assign w_chk_super = (state_q == c_ST_L1_WAIT);
   assign w_unused    = ^{csr_satp[30:20], sfence_vma, w_chk_pte[31:30], w_chk_pte[9:8], w_chk_pte[5]};
`endif

   // PTE decode: V=0, R=1, W=2, X=3, U=4, A=6, D=7
   assign w_chk_invalid = !w_chk_pte[0] || (!w_chk_pte[1] && w_chk_pte[2]);
   assign w_chk_leaf    = w_chk_pte[1] | w_chk_pte[3];
   assign w_chk_pa      = w_chk_super ? {w_chk_pte[29:20], w_cur_va[21:0]}
                                      : {w_chk_pte[29:10], w_cur_va[11:0]};

   always_comb begin
      w_chk_perm_fault = 1'b0;
      if (w_chk_super && (w_chk_pte[19:10] != 10'd0)) begin
         w_chk_perm_fault = 1'b1;
      end
      case (w_chk_type)
         c_T_INST: if (!w_chk_pte[3]) w_chk_perm_fault = 1'b1;
         c_T_LOAD: if (!w_chk_pte[1]) w_chk_perm_fault = 1'b1;
         default:  if (!w_chk_pte[2] || !w_chk_pte[7]) w_chk_perm_fault = 1'b1;
      endcase
      if (!w_chk_pte[6]) begin
         w_chk_perm_fault = 1'b1;
      end
      if ((w_chk_priv == c_PRIV_U) && !w_chk_pte[4]) begin
         w_chk_perm_fault = 1'b1;
      end
      if ((w_chk_priv == c_PRIV_S) && w_chk_pte[4] && ((w_chk_type == c_T_INST) || !w_chk_sum)) begin
         w_chk_perm_fault = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lfm_d       = lfm_q;
      w_res_load  = 1'b0;
      w_res_fault = 1'b0;
      w_res_pa    = '0;
      case (state_q)
         c_ST_IDLE: begin
            if (w_accept) begin
               if (w_bare) begin
                  state_d    = c_ST_RESP;
                  w_res_load = 1'b1;
                  w_res_pa   = req_va;
               end else if (w_hit) begin
                  state_d     = c_ST_RESP;
                  w_res_load  = 1'b1;
                  w_res_fault = w_chk_perm_fault;
                  w_res_pa    = w_chk_pa;
               end else begin
                  state_d = c_ST_L1_REQ;
                  lfm_d   = {csr_satp[19:0], req_va[31:22], 2'b00};
               end
            end
         end
         // The responder holds resolved for up to two cycles; never start a fetch under it.
         c_ST_L1_REQ: if (!LFM_resolved) state_d = c_ST_L1_WAIT;
         c_ST_L0_REQ: if (!LFM_resolved) state_d = c_ST_L0_WAIT;
         c_ST_L1_WAIT, c_ST_L0_WAIT: begin
            if (LFM_resolved) begin
               if (!w_chk_invalid && !w_chk_leaf && (state_q == c_ST_L1_WAIT)) begin
                  state_d = c_ST_L0_REQ;
                  lfm_d   = {w_pte[29:10], va_q[21:12], 2'b00};
               end else begin
                  state_d     = c_ST_RESP;
                  w_res_load  = 1'b1;
                  w_res_fault = w_chk_invalid || !w_chk_leaf || w_chk_perm_fault;
                  w_res_pa    = w_chk_pa;
               end
            end
         end
         c_ST_RESP: state_d = c_ST_IDLE;
         default:   state_d = c_ST_IDLE;
      endcase
   end

   always_comb begin
      pa_d  = pa_q;
      flt_d = flt_q;
      fva_d = fva_q;
      if (w_res_load) begin
         pa_d  = w_res_fault ? 32'd0 : w_res_pa;
         flt_d = w_res_fault ? {(w_chk_type == c_T_INST), (w_chk_type == c_T_LOAD),
                                (w_chk_type == c_T_STORE)} : 3'b000;
         fva_d = w_res_fault ? w_cur_va : 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         va_q   <= '0;
         type_q <= '0;
         priv_q <= '0;
         sum_q  <= 1'b0;
         lfm_q  <= '0;
         pa_q   <= '0;
         flt_q  <= '0;
         fva_q  <= '0;
      end else begin
         if (w_accept) begin
            va_q   <= req_va;
            type_q <= req_type;
            priv_q <= priv;
            sum_q  <= sstatus_sum;
         end
         lfm_q <= lfm_d;
         pa_q  <= pa_d;
         flt_q <= flt_d;
         fva_q <= fva_d;
      end
   end

   always_comb begin
      LFM         = lfm_q;
      LFM_enable  = 1'b0;
      stall       = w_accept;
      resp_valid  = (state_q == c_ST_RESP);
      resp_pa     = pa_q;
      instr_fault = resp_valid & flt_q[2];
      load_fault  = resp_valid & flt_q[1];
      store_fault = resp_valid & flt_q[0];
      faulting_va = fva_q;
      case (state_q)
         c_ST_L1_REQ, c_ST_L0_REQ: begin
            LFM_enable = !LFM_resolved;
            stall      = 1'b1;
         end
         c_ST_L1_WAIT, c_ST_L0_WAIT: begin
            LFM_enable = 1'b1;
            stall      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_sv32_ptw.sv
`default_nettype none
// ============================================================================
// Module   : tb_sv32_ptw
// Desc     : Directed scoreboard bench for sv32_ptw with a 6-cycle LFM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sv32_ptw;

   localparam logic [1:0] c_INST  = 2'b01;
   localparam logic [1:0] c_LOAD  = 2'b10;
   localparam logic [1:0] c_STORE = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_va = '0;
   logic [1:0]  req_type = '0;
   logic [1:0]  priv = 2'b01;
   logic        sstatus_sum = 1'b0;
   logic [31:0] csr_satp = 32'h8000_0010;
   logic        sfence_vma = 1'b0;
   logic [31:0] LFM;
   logic        LFM_enable;
   logic        LFM_resolved = 1'b0;
   logic [7:0]  b1 = '0, b2 = '0, b3 = '0, b4 = '0;
   logic        resp_valid;
   logic [31:0] resp_pa;
   logic        instr_fault, load_fault, store_fault;
   logic [31:0] faulting_va;
   logic        stall;

   sv32_ptw dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_va(req_va), .req_type(req_type),
      .priv(priv), .sstatus_sum(sstatus_sum), .csr_satp(csr_satp), .sfence_vma(sfence_vma),
      .LFM(LFM), .LFM_enable(LFM_enable), .LFM_resolved(LFM_resolved),
      .b1(b1), .b2(b2), .b3(b3), .b4(b4),
      .resp_valid(resp_valid), .resp_pa(resp_pa), .instr_fault(instr_fault),
      .load_fault(load_fault), .store_fault(store_fault), .faulting_va(faulting_va),
      .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pa;
      logic [2:0]  flt;
      logic [31:0] fva;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        exp_e;
   logic [31:0] fetch_q[$];
   logic [31:0] mem [logic [31:0]];
   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, resp_cnt = 0, en_cycles = 0;
   int rsp_st = 0, rsp_cnt = 0;
   logic [31:0] rsp_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: answers six cycles after seeing a fetch, holds resolved two cycles.
   always @(posedge clk) begin
      case (rsp_st)
         0: if (LFM_enable === 1'b1) begin
               rsp_addr <= LFM;
               rsp_cnt  <= 1;
               rsp_st   <= 1;
               fetch_q.push_back(LFM);
            end
         1: if (rsp_cnt == 5) begin
               {b4, b3, b2, b1} <= mem.exists(rsp_addr) ? mem[rsp_addr] : 32'h0;
               LFM_resolved     <= 1'b1;
               rsp_cnt          <= 0;
               rsp_st           <= 2;
            end else begin
               rsp_cnt <= rsp_cnt + 1;
            end
         default: if (rsp_cnt == 1) begin
               LFM_resolved <= 1'b0;
               rsp_st       <= 0;
            end else begin
               rsp_cnt <= rsp_cnt + 1;
            end
      endcase
   end

   always @(negedge clk) begin
      if (LFM_enable === 1'b1) en_cycles++;
      if (resp_valid === 1'b1) begin
         resp_cnt++;
         checks++;
         assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_resp observed=resp_valid pa=%0h expected=no response", resp_pa);
         end
         if (sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            checks++;
            assert (resp_pa === exp_e.pa) else begin
               errors++;
               $error("FAIL resp_pa observed=%0h expected=%0h", resp_pa, exp_e.pa);
            end
            checks++;
            assert ({instr_fault, load_fault, store_fault} === exp_e.flt) else begin
               errors++;
               $error("FAIL faults observed=%b expected=%b", {instr_fault, load_fault, store_fault}, exp_e.flt);
            end
            if (exp_e.flt != 3'b000) begin
               checks++;
               assert (faulting_va === exp_e.fva) else begin
                  errors++;
                  $error("FAIL faulting_va observed=%0h expected=%0h", faulting_va, exp_e.fva);
               end
            end
            checks++;
            assert (stall === 1'b0) else begin
               errors++;
               $error("FAIL resp_stall observed=%b expected=0", stall);
            end
            if (exp_e.lat > 0) begin
               checks++;
               assert ((cyc - acc_cyc) === exp_e.lat) else begin
                  errors++;
                  $error("FAIL latency observed=%0d expected=%0d", cyc - acc_cyc, exp_e.lat);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic issue(input logic [31:0] va, input logic [1:0] typ, input bit push,
                        input logic [31:0] epa, input logic [2:0] eflt, input int elat);
      exp_t e;
      if (push) begin
         e.pa = epa; e.flt = eflt; e.fva = va; e.lat = elat;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      req_va = va; req_type = typ; req_valid = 1'b1;
      acc_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int start;
      int n;
      start = resp_cnt;
      n = 0;
      while (resp_cnt == start && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      assert (resp_cnt != start) else begin
         errors++;
         $error("FAIL %s_timeout observed=no response expected=response", tag);
      end
   endtask

   task automatic flush();
      @(posedge clk); #1 sfence_vma = 1'b1;
      @(posedge clk); #1 sfence_vma = 1'b0;
   endtask

   function automatic logic [31:0] fq(input int i);
      return (fetch_q.size() > i) ? fetch_q[i] : 32'hFFFF_FFFF;
   endfunction

   initial begin
      int en0;
      int r0;
      int n;
      mem[32'h0001_0004] = 32'h0000_4401;
      mem[32'h0001_1004] = 32'h0000_48CF;

      repeat (2) @(negedge clk);
      chk("rst_lfm", LFM, 0);
      chk("rst_ctl", {LFM_enable, resp_valid, instr_fault, load_fault, store_fault, stall}, 0);
      chk("rst_pa", resp_pa, 0);
      chk("rst_fva", faulting_va, 0);
      rst = 1'b0;

      // bare translation
      csr_satp = 32'h0;
      en0 = en_cycles;
      issue(32'h0000_1234, c_LOAD, 1'b1, 32'h0000_1234, 3'b000, 1);
      wait_resp("bare");
      @(negedge clk);
      chk("bare_no_fetch", en_cycles - en0, 0);
      csr_satp = 32'h8000_0010;

      // two-level walk
      fetch_q.delete();
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0001_2234, 3'b000, 0);
      chk("walk_stall", stall, 1);
      wait_resp("walk2");
      chk("walk2_nfetch", fetch_q.size(), 2);
      chk("walk2_l1addr", fq(0), 32'h0001_0004);
      chk("walk2_l0addr", fq(1), 32'h0001_1004);

      // superpage and misaligned superpage
      mem[32'h0001_000C] = 32'h0010_004B;
      flush();
      issue(32'h00C0_0010, c_INST, 1'b1, 32'h0040_0010, 3'b000, 0);
      wait_resp("super");
      mem[32'h0001_000C] = 32'h0010_044B;
      flush();
      issue(32'h00C0_0010, c_INST, 1'b1, 32'h0, 3'b100, 0);
      wait_resp("super_mis");

      // permission faults
      mem[32'h0001_1004] = 32'h0000_484F;
      flush();
      issue(32'h0040_1234, c_STORE, 1'b1, 32'h0, 3'b001, 0);
      wait_resp("store_d0");
      mem[32'h0001_1004] = 32'h0000_48DF;
      flush();
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0, 3'b010, 0);
      wait_resp("load_user_nosum");
      sstatus_sum = 1'b1;
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0001_2234, 3'b000, 0);
      wait_resp("load_user_sum");
      sstatus_sum = 1'b0;

      // reset while waiting on the level-0 fetch
      mem[32'h0001_1004] = 32'h0000_48CF;
      flush();
      fetch_q.delete();
      issue(32'h0040_1234, c_LOAD, 1'b0, 32'h0, 3'b000, 0);
      n = 0;
      while (fetch_q.size() < 2 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst5_reach_l0", fetch_q.size(), 2);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst5_lfm_en", LFM_enable, 0);
      chk("rst5_stall", stall, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r0 = resp_cnt;
      repeat (15) @(posedge clk);
      chk("rst5_no_resp", resp_cnt, r0);
      fetch_q.delete();
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0001_2234, 3'b000, 0);
      wait_resp("rst5_after");
      chk("rst5_after_nfetch", fetch_q.size(), 2);

`ifdef PTW_LAST_XLATE_EN
      fetch_q.delete();
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0001_2234, 3'b000, 1);
      wait_resp("hit");
      chk("hit_no_fetch", fetch_q.size(), 0);
      flush();
      fetch_q.delete();
      issue(32'h0040_1234, c_LOAD, 1'b1, 32'h0001_2234, 3'b000, 0);
      wait_resp("after_sfence");
      chk("sfence_refetch", fetch_q.size(), 2);
`endif

      repeat (4) @(posedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
